// File: rtl/pinmux_pkg.sv
// Shared types and constants for the pad-control slice.
package pinmux_pkg;

  localparam logic [1:0] MODE_PP = 2'b00;
  localparam logic [1:0] MODE_OD = 2'b01;
  localparam logic [1:0] MODE_OS = 2'b10;
  localparam logic [1:0] MODE_HZ = 2'b11;

  // Bit layout matches the 16-bit config write/read word.
  typedef struct packed {
    logic [7:0] deb_len;
    logic       sr;
    logic       dr;
    logic       pd;
    logic       pu;
    logic       ie;
    logic [1:0] mode;
    logic       oe;
  } pad_cfg_t;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_PEND   = 1'b1
  } db_state_e;

endpackage

// File: rtl/pinmux_in_filter.sv
// One pad input channel: 2-flop synchroniser, debounce filter, sticky edge flag.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   DB_STABLE | synchronised level matches in_val, counter idle at 0
//   DB_PEND   | level differs from in_val, counting cycles toward deb_len
module pinmux_in_filter
  import pinmux_pkg::*;
#(
  parameter int DEB_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pad_y,
  input  logic             ie,
  input  logic [DEB_W-1:0] deb_len,
  input  logic             pend_clr,
  output logic             in_val,
  output logic             edge_pend
);

  localparam logic [DEB_W-1:0] CNT_MAX = '1;
  localparam logic [DEB_W-1:0] CNT_ONE = DEB_W'(1);

  logic             sync1;
  logic             s;
  logic             in_val_d;
  db_state_e        state;
  logic [DEB_W-1:0] cnt;
  logic [DEB_W-1:0] cnt_inc;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // Gate by input enable, then synchronise the asynchronous pad level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= pad_y & ie;
      s     <= sync1;
    end
  end

  // Debounce: accept a new level only after it has held for deb_len cycles.
  // deb_len of 0 or 1 both accept on the first differing cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DB_STABLE;
      cnt    <= '0;
      in_val <= 1'b0;
    end else begin
      case (state)
        DB_STABLE: begin
          if (s != in_val) begin
            if (deb_len <= CNT_ONE) begin
              in_val <= s;
              cnt    <= '0;
            end else begin
              cnt   <= CNT_ONE;
              state <= DB_PEND;
            end
          end else begin
            cnt <= '0;
          end
        end
        DB_PEND: begin
          if (s == in_val) begin
            cnt   <= '0;
            state <= DB_STABLE;
          end else if (cnt_inc >= deb_len) begin
            in_val <= s;
            cnt    <= '0;
            state  <= DB_STABLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          cnt   <= '0;
          state <= DB_STABLE;
        end
      endcase
    end
  end

  // Sticky edge flag; a new edge outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_val_d  <= 1'b0;
      edge_pend <= 1'b0;
    end else begin
      in_val_d  <= in_val;
      edge_pend <= (in_val ^ in_val_d) | (edge_pend & ~pend_clr);
    end
  end

endmodule

// File: rtl/pinmux_pad_ctrl.sv
// N-channel pad controller: config registers, registered pad drive, input conditioning.
module pinmux_pad_ctrl
  import pinmux_pkg::*;
#(
  parameter int NCH   = 16,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int DEB_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_sel,
  input  logic [15:0]     cfg_wdata,
  output logic [15:0]     cfg_rdata,
  input  logic [NCH-1:0]  func_a,
  input  logic [NCH-1:0]  func_oe,
  output logic [NCH-1:0]  pad_a,
  output logic [NCH-1:0]  pad_oe,
  output logic [NCH-1:0]  pad_od,
  output logic [NCH-1:0]  pad_os,
  output logic [NCH-1:0]  pad_pu,
  output logic [NCH-1:0]  pad_pd,
  output logic [NCH-1:0]  pad_ie,
  output logic [NCH-1:0]  pad_dr,
  output logic [NCH-1:0]  pad_sr,
  input  logic [NCH-1:0]  pad_y,
  output logic [NCH-1:0]  in_val,
  output logic [NCH-1:0]  edge_pend,
  input  logic [NCH-1:0]  pend_clr,
  output logic            irq
);

  pad_cfg_t cfg_q [NCH];
  logic     sel_ok;

  assign sel_ok = (int'(cfg_sel) < NCH);

  // Config register file; out-of-range selects are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cfg_q[i] <= '0;
    end else if (cfg_we && sel_ok) begin
      cfg_q[cfg_sel] <= pad_cfg_t'(cfg_wdata);
    end
  end

  // Registered readback with write-through for a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst || !sel_ok) begin
      cfg_rdata <= '0;
    end else if (cfg_we) begin
      cfg_rdata <= cfg_wdata;
    end else begin
      cfg_rdata <= cfg_q[cfg_sel];
    end
  end

  // Registered pad drive; high-Z mode kills OE, pu+pd together cancels both.
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_a  <= '0;
      pad_oe <= '0;
      pad_od <= '0;
      pad_os <= '0;
      pad_pu <= '0;
      pad_pd <= '0;
      pad_ie <= '0;
      pad_dr <= '0;
      pad_sr <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        pad_a[i]  <= func_a[i];
        pad_oe[i] <= cfg_q[i].oe & func_oe[i] & (cfg_q[i].mode != MODE_HZ);
        pad_od[i] <= cfg_q[i].mode[0];
        pad_os[i] <= cfg_q[i].mode[1];
        pad_pu[i] <= cfg_q[i].pu & ~cfg_q[i].pd;
        pad_pd[i] <= cfg_q[i].pd & ~cfg_q[i].pu;
        pad_ie[i] <= cfg_q[i].ie;
        pad_dr[i] <= cfg_q[i].dr;
        pad_sr[i] <= cfg_q[i].sr;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DEB_W-1:0] deb_len;
    assign deb_len = DEB_W'(cfg_q[g].deb_len);

    pinmux_in_filter #(
      .DEB_W (DEB_W)
    ) u_filt (
      .clk       (clk),
      .rst       (rst),
      .pad_y     (pad_y[g]),
      .ie        (pad_ie[g]),
      .deb_len   (deb_len),
      .pend_clr  (pend_clr[g]),
      .in_val    (in_val[g]),
      .edge_pend (edge_pend[g])
    );
  end

  // Interrupt is the registered OR of all pending flags.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |edge_pend;
  end

endmodule

// File: tb/tb_pinmux_pad_ctrl.sv
// Directed bench for pinmux_pad_ctrl (12 channels so an out-of-range select exists).
module tb_pinmux_pad_ctrl;

  localparam int NCH   = 12;
  localparam int CH_W  = 4;
  localparam int DEB_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [CH_W-1:0] cfg_sel;
  logic [15:0]     cfg_wdata;
  logic [15:0]     cfg_rdata;
  logic [NCH-1:0]  func_a, func_oe;
  logic [NCH-1:0]  pad_a, pad_oe, pad_od, pad_os, pad_pu, pad_pd, pad_ie, pad_dr, pad_sr;
  logic [NCH-1:0]  pad_y, in_val, edge_pend, pend_clr;
  logic            irq;

  int n_chk  = 0;
  int n_fail = 0;

  pinmux_pad_ctrl #(.NCH(NCH), .CH_W(CH_W), .DEB_W(DEB_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .func_a    (func_a),
    .func_oe   (func_oe),
    .pad_a     (pad_a),
    .pad_oe    (pad_oe),
    .pad_od    (pad_od),
    .pad_os    (pad_os),
    .pad_pu    (pad_pu),
    .pad_pd    (pad_pd),
    .pad_ie    (pad_ie),
    .pad_dr    (pad_dr),
    .pad_sr    (pad_sr),
    .pad_y     (pad_y),
    .in_val    (in_val),
    .edge_pend (edge_pend),
    .pend_clr  (pend_clr),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are looked at 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [CH_W-1:0] sel, input logic [15:0] data);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_wdata = data;
    tick();
    cfg_we    = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cfg_we    = 1'b0;
    cfg_sel   = '0;
    cfg_wdata = '0;
    func_a    = '0;
    func_oe   = '1;
    pad_y     = '0;
    pend_clr  = '0;

    // Reset state
    tick(2);
    chk("rst_pad_oe", pad_oe, 0);
    chk("rst_pad_misc", {pad_a, pad_od, pad_os, pad_pu, pad_pd, pad_ie, pad_dr, pad_sr}, 0);
    chk("rst_rdata", cfg_rdata, 0);
    chk("rst_irq", irq, 0);
    chk("rst_in_val", in_val, 0);
    rst = 1'b0;

    // ch3: deb=0, ie=1, mode=open-drain, oe=1 -> word 0x000B
    wr(4'd3, 16'h000B);
    chk("ch3_rdata_wr", cfg_rdata, 16'h000B);
    tick();
    chk("ch3_pad_oe", pad_oe, 12'h008);
    chk("ch3_pad_od", pad_od[3], 1);
    chk("ch3_pad_os", pad_os[3], 0);
    chk("ch3_pad_ie", pad_ie, 12'h008);

    // ch3 bypass filter: 3-cycle latency, then pending, then irq
    pad_y[3] = 1'b1;
    tick(2);
    chk("ch3_inval_early", in_val[3], 0);
    tick();
    chk("ch3_inval_3cyc", in_val[3], 1);
    chk("ch3_pend_early", edge_pend[3], 0);
    tick();
    chk("ch3_pend", edge_pend[3], 1);
    chk("ch3_irq_early", irq, 0);
    tick();
    chk("ch3_irq", irq, 1);
    pend_clr[3] = 1'b1;
    tick();
    pend_clr[3] = 1'b0;
    chk("ch3_pend_clr", edge_pend[3], 0);
    tick();
    chk("ch3_irq_clr", irq, 0);

    // ch5: deb=4, ie=1 -> word 0x0408
    wr(4'd5, 16'h0408);
    tick();
    chk("ch5_pad_ie", pad_ie, 12'h028);

    // 3-cycle glitch is rejected
    pad_y[5] = 1'b1;
    tick(3);
    pad_y[5] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("ch5_glitch_inval", in_val[5], 0);
    end
    chk("ch5_glitch_pend", edge_pend[5], 0);

    // 10-cycle pulse: accepted 2+4 cycles after the pad edge
    pad_y[5] = 1'b1;
    tick(5);
    chk("ch5_rise_early", in_val[5], 0);
    tick();
    chk("ch5_rise", in_val[5], 1);
    tick();
    chk("ch5_rise_pend", edge_pend[5], 1);
    pend_clr[5] = 1'b1;
    tick();
    pend_clr[5] = 1'b0;
    chk("ch5_rise_clr", edge_pend[5], 0);
    tick(2);
    pad_y[5] = 1'b0;
    tick(5);
    chk("ch5_fall_early", in_val[5], 1);
    tick();
    chk("ch5_fall", in_val[5], 0);

    // clear in the same cycle as a new edge: set wins
    pend_clr[5] = 1'b1;
    tick();
    pend_clr[5] = 1'b0;
    chk("ch5_set_wins", edge_pend[5], 1);
    pend_clr[5] = 1'b1;
    tick();
    pend_clr[5] = 1'b0;
    chk("ch5_clr_alone", edge_pend[5], 0);
    chk("ch5_irq_lag", irq, 1);
    tick();
    chk("ch5_irq_drop", irq, 0);

    // ch7 high-Z with oe=1 and func_oe=1 -> pad_oe stays 0
    wr(4'd7, 16'h0007);
    tick();
    chk("hz_pad_oe", pad_oe, 12'h008);
    chk("hz_od_os", {pad_od[7], pad_os[7]}, 2'b11);

    // ch8 pu+pd -> both off; ch9 pu alone -> pu on
    wr(4'd8, 16'h0030);
    wr(4'd9, 16'h0010);
    tick();
    chk("pupd_pu", pad_pu, 12'h200);
    chk("pupd_pd", pad_pd, 12'h000);

    // pad_a follows func_a one cycle later
    func_a = 12'hA5C;
    tick();
    chk("pad_a", pad_a, 12'hA5C);

    // out-of-range write is ignored and reads back 0
    wr(4'd12, 16'hFFFF);
    chk("oor_rdata", cfg_rdata, 0);
    tick();
    chk("oor_pad_oe", pad_oe, 12'h008);
    chk("oor_pad_ie", pad_ie, 12'h028);
    chk("oor_pad_drsr", {pad_dr, pad_sr}, 0);
    chk("oor_pad_pu", pad_pu, 12'h200);
    cfg_sel = 4'd3;
    tick();
    chk("ch3_readback", cfg_rdata, 16'h000B);
    cfg_sel = 4'd5;
    tick();
    chk("ch5_readback", cfg_rdata, 16'h0408);

    // reset in the middle of a debounce
    pad_y[5] = 1'b1;
    tick(4);
    chk("mid_deb_inval", in_val[5], 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_inval", in_val, 0);
    chk("rst2_pend", edge_pend, 0);
    chk("rst2_pad_ie", pad_ie, 0);
    chk("rst2_rdata", cfg_rdata, 0);
    tick(6);
    chk("rst2_inval_hold", in_val, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
